instr_buffer: RTL and testbench
===============================

# instr_buffer

Instruction buffer between the fetch stage and the instruction decoder. It queues fetched {pc, instruction, fetch-exception} entries in first-in-first-out order and presents the oldest entry to the decoder through a valid/ready handshake. Fetch and decode can therefore stall independently. A pipeline flush (branch mispredict or exception redirect) empties the buffer in one cycle.

## Interface

Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all entries; takes effect at the next edge.
- fetch_valid_i  in  1  fetch presents an entry.
- fetch_ready_o  out  1  buffer can accept an entry.
- fetch_pc_i  in  32  pc of the entry.
- fetch_instr_i  in  32  instruction word.
- fetch_adef_i  in  1  fetch address-error flag travelling with the entry.
- dec_valid_o  out  1  head entry is valid.
- dec_ready_i  in  1  decoder consumes the head entry.
- dec_pc_o  out  32  head pc.
- dec_instr_o  out  32  head instruction; feeds the decoder's instr input.
- dec_adef_o  out  1  head address-error flag.
- count_o  out  CNT_W  current occupancy, 0..DEPTH.

## Operation

- Storage: DEPTH entries of 65 bits. Read pointer and write pointer are each $clog2(DEPTH) bits; count register is CNT_W bits.
- push = fetch_valid_i & fetch_ready_o. Entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- pop = dec_valid_o & dec_ready_i. rd_ptr increments modulo DEPTH.
- fetch_ready_o = (count != DEPTH). It is combinational from registered state only and does not depend on dec_ready_i. There is no pop-through-when-full.
- dec_valid_o = (count != 0). dec_pc_o, dec_instr_o and dec_adef_o are read combinationally from the entry at rd_ptr (first-word fall-through).
- count update: count + push − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- flush_i has priority over push and pop in the same cycle. At the next edge, rd_ptr = wr_ptr = 0 and count = 0. Any push or pop in the flush cycle is discarded: the entry is not written and no pointer advances. Handshake outputs in the flush cycle still follow the rules above.
- Data outputs while dec_valid_o = 0 are the stale contents of entry rd_ptr. The bench must not check them.
- Ordering: entries leave in exactly the order they were accepted. Fields are never reordered, modified or dropped except by flush or reset.

## Timing

- Reset (asynchronous, any time, including mid-transfer): rd_ptr = 0, wr_ptr = 0, count = 0, all storage = 0.
  - Hence during and after reset: fetch_ready_o = 1, dec_valid_o = 0, dec_pc_o = 0, dec_instr_o = 0, dec_adef_o = 0, count_o = 0.
  - Release is synchronous to clk through the standard reset synchronizer upstream.
- Latency: an entry pushed at edge N is visible with dec_valid_o = 1 in the cycle after edge N. Minimum residency is 1 cycle; there is no bypass from fetch to decode.
- Throughput: 1 push and 1 pop per cycle sustained.
- Stall: while dec_valid_o = 1 and dec_ready_i = 0, the head outputs hold stable.
- Full: when count = DEPTH, fetch_ready_o = 0. A pop at that edge re-asserts fetch_ready_o in the following cycle.
- Empty: when count = 0, dec_valid_o = 0 and dec_ready_i is ignored.
- After flush: the buffer is empty in the next cycle. A push in that next cycle lands in entry 0.

## Test plan

- Reset value check: assert rst mid-cycle with 3 entries held. Required: immediately fetch_ready_o = 1, dec_valid_o = 0, count_o = 0, data outputs 0. After release, pushing pc 0x1C000000 yields dec_pc_o = 0x1C000000 one cycle later.
- Fill and full: with dec_ready_i = 0, push 8 entries (pc 0x100, 0x104, …, 0x11C). Required: count_o = 8 and fetch_ready_o = 0. A 9th fetch_valid_i is not accepted. Then one pop gives dec_pc_o 0x100 → 0x104 and fetch_ready_o = 1 the next cycle.
- Streaming with wrap: push and pop every cycle for 20 entries, instr = 0x02800000 + i. Required: count_o stays 1 after the first cycle, pointers wrap past 7, and output order is exact with adef bits preserved.
- Backpressure hold: head instr 0x0280_0421 with dec_ready_i = 0 for 5 cycles while fetch keeps pushing. Required: head outputs unchanged for 5 cycles and count_o increments each cycle until 8.
- Flush with simultaneous push/pop: count = 5, then flush_i = 1 in the same cycle as a push and a pop. Required: next cycle count_o = 0, dec_valid_o = 0, and the pushed entry is absent. A push on the following cycle appears as head with count_o = 1.
- Address-error propagation: push an entry with fetch_adef_i = 1 between two normal entries. Required: dec_adef_o = 1 only while that entry is at the head.

Source files
------------

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of
// {adef, pc, instr} with first-word fall-through and single-cycle flush.
module instr_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [31:0]      fetch_pc_i,
  input  logic [31:0]      fetch_instr_i,
  input  logic             fetch_adef_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [31:0]      dec_pc_o,
  output logic [31:0]      dec_instr_o,
  output logic             dec_adef_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [64:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [64:0]      w_head;

  assign fetch_ready_o = (r_count != CNT_W'(DEPTH));
  assign dec_valid_o   = (r_count != '0);
  assign w_push        = fetch_valid_i & fetch_ready_o;
  assign w_pop         = dec_valid_o & dec_ready_i;

  always_comb begin
    w_head = r_mem[r_rd_ptr];
  end

  assign dec_adef_o  = w_head[64];
  assign dec_pc_o    = w_head[63:32];
  assign dec_instr_o = w_head[31:0];
  assign count_o     = r_count;

  // Flush wins over any push/pop in the same cycle; storage is left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {fetch_adef_i, fetch_pc_i, fetch_instr_i};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus random traffic,
// compared against a queue-based FIFO model.
module tb_instr_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush_i = 1'b0;
  logic             fetch_valid_i = 1'b0;
  logic             fetch_ready_o;
  logic [31:0]      fetch_pc_i = '0;
  logic [31:0]      fetch_instr_i = '0;
  logic             fetch_adef_i = 1'b0;
  logic             dec_valid_o;
  logic             dec_ready_i = 1'b0;
  logic [31:0]      dec_pc_o;
  logic [31:0]      dec_instr_o;
  logic             dec_adef_o;
  logic [CNT_W-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries held as {adef, pc, instr}, oldest at index 0.
  logic [64:0] q[$];

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i), .fetch_adef_i(fetch_adef_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o), .dec_adef_o(dec_adef_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus from a negedge, advance the model at the posedge,
  // and return at the following negedge with inputs idle.
  task automatic step(input logic fl, input logic fv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ad, input logic dr);
    bit p, o;
    flush_i = fl; fetch_valid_i = fv; fetch_pc_i = pc;
    fetch_instr_i = instr; fetch_adef_i = ad; dec_ready_i = dr;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      p = fv && (q.size() < DEPTH);
      o = dr && (q.size() > 0);
      if (o) void'(q.pop_front());
      if (p) q.push_back({ad, pc, instr});
    end
    @(negedge clk);
    flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      n_checks++;
      if ({dec_adef_o, dec_pc_o, dec_instr_o} !== q[0]) begin
        n_fail++;
        $display("FAIL drain_order: got %h required %h", {dec_adef_o, dec_pc_o, dec_instr_o}, q[0]);
      end
      step(0, 0, '0, '0, 0, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o, dec_adef_o} !==
        {1'b1, 1'b0, CNT_W'(0), 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: rdy=%b val=%b cnt=%0d pc=%h ins=%h adef=%b required 1 0 0 0 0 0",
               fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o, dec_adef_o);
    end
    @(negedge clk); rst = 1'b0; q.delete();
    for (int i = 0; i < 3; i++) step(0, 1, 32'h2000 + 32'(4 * i), $urandom, 1'b1, 0);
    n_checks++;
    if (count_o !== CNT_W'(3)) begin
      n_fail++; $display("FAIL reset_preload_count: got %0d required 3", count_o);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o, dec_adef_o} !==
        {1'b1, 1'b0, CNT_W'(0), 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midcycle: rdy=%b val=%b cnt=%0d pc=%h ins=%h adef=%b required 1 0 0 0 0 0",
               fetch_ready_o, dec_valid_o, count_o, dec_pc_o, dec_instr_o, dec_adef_o);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0; q.delete();
    step(0, 1, 32'h1C00_0000, 32'h0280_0000, 0, 0);
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h1C00_0000) begin
      n_fail++; $display("FAIL reset_first_push: val=%b pc=%h required 1 1c000000", dec_valid_o, dec_pc_o);
    end
    drain();
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h100 + 32'(4 * i), $urandom, 0, 0);
    n_checks++;
    if (count_o !== CNT_W'(8) || fetch_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_state: cnt=%0d rdy=%b required 8 0", count_o, fetch_ready_o);
    end
    step(0, 1, 32'h999, 32'h999, 1, 0);
    n_checks++;
    if (count_o !== CNT_W'(8) || dec_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL full_reject: cnt=%0d pc=%h required 8 100", count_o, dec_pc_o);
    end
    step(0, 0, '0, '0, 0, 1);
    n_checks++;
    if (dec_pc_o !== 32'h104 || fetch_ready_o !== 1'b1 || count_o !== CNT_W'(7)) begin
      n_fail++;
      $display("FAIL full_pop: pc=%h rdy=%b cnt=%0d required 104 1 7", dec_pc_o, fetch_ready_o, count_o);
    end
    drain();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      step(0, 1, $urandom, 32'h0280_0000 + 32'(i), 1'($urandom), 1);
      n_checks++;
      if (count_o !== CNT_W'(1) || dec_instr_o !== 32'h0280_0000 + 32'(i) ||
          {dec_adef_o, dec_pc_o, dec_instr_o} !== q[0]) begin
        n_fail++;
        $display("FAIL stream_%0d: cnt=%0d head=%h required 1 %h", i, count_o,
                 {dec_adef_o, dec_pc_o, dec_instr_o}, q[0]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    step(0, 1, 32'h1C00_0040, 32'h0280_0421, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, $urandom, $urandom, 1'($urandom), 0);
      n_checks++;
      if (dec_instr_o !== 32'h0280_0421 || dec_pc_o !== 32'h1C00_0040 || dec_adef_o !== 1'b0 ||
          count_o !== CNT_W'((k + 1 > 8) ? 8 : k + 1)) begin
        n_fail++;
        $display("FAIL backpressure_%0d: ins=%h pc=%h cnt=%0d required 02800421 1c000040 %0d",
                 k, dec_instr_o, dec_pc_o, count_o, (k + 1 > 8) ? 8 : k + 1);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(0, 1, 32'h300 + 32'(4 * i), $urandom, 0, 0);
    n_checks++;
    if (count_o !== CNT_W'(5) || fetch_ready_o !== 1'b1 || dec_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: cnt=%0d rdy=%b val=%b required 5 1 1", count_o, fetch_ready_o, dec_valid_o);
    end
    step(1, 1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1, 1);
    n_checks++;
    if (count_o !== CNT_W'(0) || dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: cnt=%0d val=%b rdy=%b required 0 0 1", count_o, dec_valid_o, fetch_ready_o);
    end
    step(0, 1, 32'h1C00_0800, 32'h0280_0777, 0, 0);
    n_checks++;
    if (count_o !== CNT_W'(1) || dec_pc_o !== 32'h1C00_0800 || dec_instr_o !== 32'h0280_0777) begin
      n_fail++;
      $display("FAIL flush_next_push: cnt=%0d pc=%h ins=%h required 1 1c000800 02800777",
               count_o, dec_pc_o, dec_instr_o);
    end
    drain();
  endtask

  task automatic test_adef();
    logic exp_adef[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) step(0, 1, 32'h500 + 32'(4 * i), $urandom, exp_adef[i], 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dec_adef_o !== exp_adef[i] || dec_pc_o !== 32'h500 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL adef_%0d: adef=%b pc=%h required %b %h", i, dec_adef_o, dec_pc_o,
                 exp_adef[i], 32'h500 + 32'(4 * i));
      end
      step(0, 0, '0, '0, 0, 1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_checks++;
      if (fetch_ready_o !== (q.size() < DEPTH) || dec_valid_o !== (q.size() > 0) ||
          count_o !== CNT_W'(q.size()) ||
          (q.size() > 0 && {dec_adef_o, dec_pc_o, dec_instr_o} !== q[0])) begin
        n_fail++;
        $display("FAIL random_%0d: rdy=%b val=%b cnt=%0d head=%h required cnt=%0d head=%h", c,
                 fetch_ready_o, dec_valid_o, count_o, {dec_adef_o, dec_pc_o, dec_instr_o},
                 q.size(), (q.size() > 0) ? q[0] : 65'h0);
      end
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
           1'($urandom), $urandom_range(0, 2) != 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_stream();
    test_backpressure();
    test_flush();
    test_adef();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
